// File: rtl/bist_pkg.sv
// ============================================================================
// Module      : bist_pkg
// Description : Shared types, default constants and the MISR update function
//               for the BIST output-response analyzer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bist_pkg;

   // Analyzer run states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPACT = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Default MISR feedback polynomial and start value.
   localparam logic [31:0] POLY_DEFAULT = 32'h04C1_1DB7;
   localparam logic [31:0] SEED_DEFAULT = 32'h0000_0000;

   // Widest MISR the shared update function can handle.
   localparam int MISR_MAX_W = 64;

   // One MISR step on a register whose top bit sits at index msb:
   // shift left, fold the polynomial in when the outgoing bit was set,
   // then XOR the incoming word. Bits above msb are cleared.
   function automatic logic [MISR_MAX_W-1:0] misr_next(
      input logic [MISR_MAX_W-1:0] sig,
      input logic [MISR_MAX_W-1:0] word,
      input logic [MISR_MAX_W-1:0] poly,
      input logic [5:0]            msb
   );
      logic [MISR_MAX_W-1:0] mask;
      logic [MISR_MAX_W-1:0] nxt;
      mask = '0;
      for (int i = 0; i < MISR_MAX_W; i++) begin
         mask[i] = (i <= int'(msb));
      end
      nxt = {sig[MISR_MAX_W-2:0], 1'b0} ^ (sig[msb] ? poly : '0);
      nxt = (nxt ^ word) & mask;
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bist_response_analyzer_if.sv
// ============================================================================
// Module      : bist_response_analyzer_if
// Description : Response-word handshake between the pattern source (master)
//               and the response analyzer (slave). With BIST_RESP_XMASK_EN
//               defined, a per-bit don't-care mask travels with each word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bist_response_analyzer_if #(
   parameter int RESP_W = 25
);
   logic              resp_valid;
   logic [RESP_W-1:0] resp_data;
   logic              resp_ready;
`ifdef BIST_RESP_XMASK_EN
   logic [RESP_W-1:0] resp_mask;
`endif

   modport master (
      input  resp_ready,
      output resp_valid,
      output resp_data
`ifdef BIST_RESP_XMASK_EN
      , output resp_mask
`endif
   );

   modport slave (
      output resp_ready,
      input  resp_valid,
      input  resp_data
`ifdef BIST_RESP_XMASK_EN
      , input  resp_mask
`endif
   );
endinterface

`default_nettype wire

// File: rtl/bist_misr.sv
// ============================================================================
// Module      : bist_misr
// Description : Multiple-input signature register with synchronous seed load
//               and per-word compaction enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_misr
   import bist_pkg::*;
#(
   parameter int               SIG_W = 32,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT),
   parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEFAULT)
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             load_i,
   input  wire logic             en_i,
   input  wire logic [SIG_W-1:0] word_i,
   output logic      [SIG_W-1:0] sig_o
);

   localparam logic [5:0] SIG_MSB = 6'(SIG_W - 1);

   generate
      if (SIG_W < 2 || SIG_W > MISR_MAX_W) begin : g_bad_width
         $error("bist_misr: SIG_W out of supported range");
      end
   endgenerate

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   assign sig_d = SIG_W'(misr_next(MISR_MAX_W'(sig_q), MISR_MAX_W'(word_i),
                                   MISR_MAX_W'(POLY), SIG_MSB));

   // Signature register: seed load wins over compaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else if (load_i) begin
         sig_q <= SEED;
      end else if (en_i) begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

`default_nettype wire

// File: rtl/bist_response_analyzer.sv
// ============================================================================
// Module      : bist_response_analyzer
// Description : Compacts a fixed number of CUT response words into a MISR
//               signature and compares it against a golden value.
//               Optional macro BIST_RESP_XMASK_EN masks don't-care response
//               bits (resp_mask on the interface) before compaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_response_analyzer
   import bist_pkg::*;
#(
   parameter int               RESP_W       = 25,
   parameter int               SIG_W        = 32,
   parameter logic [SIG_W-1:0] POLY         = SIG_W'(POLY_DEFAULT),
   parameter logic [SIG_W-1:0] SEED         = SIG_W'(SEED_DEFAULT),
   parameter int               NUM_PATTERNS = 1024,
   parameter int               CNT_W        = 11
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   input  wire logic                 start,
   bist_response_analyzer_if.slave   resp,
   input  wire logic [SIG_W-1:0]     golden_sig,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic      [SIG_W-1:0]     signature,
   output logic      [CNT_W-1:0]     pat_count
);

   // Configurations that would truncate responses or wrap the counter are rejected.
   generate
      if (SIG_W < RESP_W) begin : g_bad_sig_w
         $error("bist_response_analyzer: SIG_W must be >= RESP_W");
      end
      if (NUM_PATTERNS < 1 ||
          longint'(NUM_PATTERNS) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_count
         $error("bist_response_analyzer: NUM_PATTERNS does not fit CNT_W");
      end
   endgenerate

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic             misr_load;
   logic             misr_en;
   logic             ready;
   logic [RESP_W-1:0] word_masked;

`ifdef BIST_RESP_XMASK_EN
   assign word_masked = resp.resp_data & ~resp.resp_mask;
`else
   assign word_masked = resp.resp_data;
`endif

   bist_misr #(
      .SIG_W (SIG_W),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (misr_load),
      .en_i   (misr_en),
      .word_i (SIG_W'(word_masked)),
      .sig_o  (signature)
   );

   // State, pattern counter and verdict registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state, handshake and status decoding.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            done = (state_q == ST_DONE);
            if (start) begin
               state_d   = ST_COMPACT;
               cnt_d     = '0;
               pass_d    = 1'b0;
               misr_load = 1'b1;
            end
         end
         ST_COMPACT: begin
            ready = 1'b1;
            busy  = 1'b1;
            if (resp.resp_valid) begin
               misr_en = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_COMPARE;
               end
            end
         end
         ST_COMPARE: begin
            busy    = 1'b1;
            pass_d  = (signature == golden_sig);
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign resp.resp_ready = ready;
   assign pass            = pass_q;
   assign pat_count       = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_response_analyzer.sv
// ============================================================================
// Module      : tb_bist_response_analyzer
// Description : Directed self-checking bench for bist_response_analyzer.
//               Exercises the mask path when BIST_RESP_XMASK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_response_analyzer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_start = 1'b0;
   logic        b_start = 1'b0;
   logic [31:0] a_golden = 32'h0;
   logic [31:0] b_golden = 32'h0;

   logic        a_busy, a_done, a_pass;
   logic [31:0] a_sig;
   logic [10:0] a_cnt;
   logic        b_busy, b_done, b_pass;
   logic [31:0] b_sig;
   logic [10:0] b_cnt;

   int checks = 0;
   int errors = 0;

   bist_response_analyzer_if #(.RESP_W(25)) a_if ();
   bist_response_analyzer_if #(.RESP_W(25)) b_if ();

   bist_response_analyzer #(
      .NUM_PATTERNS (2),
      .SEED         (32'h0)
   ) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (a_start),
      .resp       (a_if.slave),
      .golden_sig (a_golden),
      .busy       (a_busy),
      .done       (a_done),
      .pass       (a_pass),
      .signature  (a_sig),
      .pat_count  (a_cnt)
   );

   bist_response_analyzer #(
      .NUM_PATTERNS (1),
      .SEED         (32'h8000_0000)
   ) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (b_start),
      .resp       (b_if.slave),
      .golden_sig (b_golden),
      .busy       (b_busy),
      .done       (b_done),
      .pass       (b_pass),
      .signature  (b_sig),
      .pat_count  (b_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_if.resp_valid = 1'b0;
      a_if.resp_data  = '0;
      b_if.resp_valid = 1'b0;
      b_if.resp_data  = '0;
`ifdef BIST_RESP_XMASK_EN
      a_if.resp_mask  = '0;
      b_if.resp_mask  = '0;
`endif

      // Reset values
      step(); step();
      check("rst_ready", 32'(a_if.resp_ready), 32'd0);
      check("rst_busy",  32'(a_busy), 32'd0);
      check("rst_done",  32'(a_done), 32'd0);
      check("rst_pass",  32'(a_pass), 32'd0);
      check("rst_sig",   a_sig, 32'd0);
      check("rst_cnt",   32'(a_cnt), 32'd0);
      rst_n = 1'b1;
      step();

      // Basic pass: 1,1 -> 3
      a_golden = 32'h3;
      a_start = 1'b1; step(); a_start = 1'b0;
      check("bp_busy",  32'(a_busy), 32'd1);
      check("bp_ready", 32'(a_if.resp_ready), 32'd1);
      check("bp_seed",  a_sig, 32'd0);
      a_if.resp_valid = 1'b1; a_if.resp_data = 25'd1; step();
      check("bp_sig1",  a_sig, 32'd1);
      check("bp_cnt1",  32'(a_cnt), 32'd1);
      step();
      a_if.resp_valid = 1'b0; a_if.resp_data = 25'd9;
      check("bp_sig2",     a_sig, 32'd3);
      check("bp_cnt2",     32'(a_cnt), 32'd2);
      check("bp_cmp_done", 32'(a_done), 32'd0);
      check("bp_cmp_busy", 32'(a_busy), 32'd1);
      check("bp_cmp_rdy",  32'(a_if.resp_ready), 32'd0);
      step();
      check("bp_done", 32'(a_done), 32'd1);
      check("bp_pass", 32'(a_pass), 32'd1);
      check("bp_busy0", 32'(a_busy), 32'd0);
      a_if.resp_valid = 1'b1; a_if.resp_data = 25'd5; step();
      a_if.resp_valid = 1'b0;
      check("bp_hold_sig",  a_sig, 32'd3);
      check("bp_hold_cnt",  32'(a_cnt), 32'd2);
      check("bp_hold_done", 32'(a_done), 32'd1);

      // Fail: same stream, golden 4
      a_golden = 32'h4;
      a_start = 1'b1; step(); a_start = 1'b0;
      check("fl_done0", 32'(a_done), 32'd0);
      check("fl_pass0", 32'(a_pass), 32'd0);
      check("fl_cnt0",  32'(a_cnt), 32'd0);
      a_if.resp_valid = 1'b1; a_if.resp_data = 25'd1; step(); step();
      a_if.resp_valid = 1'b0;
      step();
      check("fl_done", 32'(a_done), 32'd1);
      check("fl_pass", 32'(a_pass), 32'd0);
      check("fl_sig",  a_sig, 32'd3);

      // Gaps and start pulsed mid-run
      a_golden = 32'h3;
      a_start = 1'b1; step(); a_start = 1'b0;
      a_if.resp_valid = 1'b1; a_if.resp_data = 25'd1; step();
      a_if.resp_valid = 1'b0; a_if.resp_data = 25'h1ABCDE; step(); step();
      a_start = 1'b1; step(); a_start = 1'b0;
      check("gp_cnt",  32'(a_cnt), 32'd1);
      check("gp_sig",  a_sig, 32'd1);
      check("gp_busy", 32'(a_busy), 32'd1);
      a_if.resp_valid = 1'b1; a_if.resp_data = 25'd1; step();
      a_if.resp_valid = 1'b0;
      check("gp_sig2", a_sig, 32'd3);
      check("gp_cnt2", 32'(a_cnt), 32'd2);
      step();
      check("gp_done", 32'(a_done), 32'd1);
      check("gp_pass", 32'(a_pass), 32'd1);

      // Reset mid-run
      a_start = 1'b1; step(); a_start = 1'b0;
      a_if.resp_valid = 1'b1; a_if.resp_data = 25'd1; step();
      a_if.resp_valid = 1'b0;
      check("mr_cnt1", 32'(a_cnt), 32'd1);
      rst_n = 1'b0; #1;
      check("mr_busy",  32'(a_busy), 32'd0);
      check("mr_ready", 32'(a_if.resp_ready), 32'd0);
      check("mr_sig",   a_sig, 32'd0);
      check("mr_cnt",   32'(a_cnt), 32'd0);
      check("mr_pass",  32'(a_pass), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      a_start = 1'b1; step(); a_start = 1'b0;
      a_if.resp_valid = 1'b1; a_if.resp_data = 25'd1; step(); step();
      a_if.resp_valid = 1'b0;
      step();
      check("mr_re_sig",  a_sig, 32'd3);
      check("mr_re_done", 32'(a_done), 32'd1);
      check("mr_re_pass", 32'(a_pass), 32'd1);

      // Feedback tap: seed 0x80000000, one zero word
      b_start = 1'b1; step(); b_start = 1'b0;
      check("fb_seed", b_sig, 32'h8000_0000);
      b_if.resp_valid = 1'b1; b_if.resp_data = 25'd0; step();
      b_if.resp_valid = 1'b0;
      check("fb_sig", b_sig, 32'h04C1_1DB7);
      check("fb_cnt", 32'(b_cnt), 32'd1);
      step();
      check("fb_done", 32'(b_done), 32'd1);

`ifdef BIST_RESP_XMASK_EN
      // Masked compaction: (3 & ~2)=1 then 1 -> 3
      a_golden = 32'h3;
      a_start = 1'b1; step(); a_start = 1'b0;
      a_if.resp_valid = 1'b1; a_if.resp_data = 25'd3; a_if.resp_mask = 25'd2; step();
      check("mk_sig1", a_sig, 32'd1);
      a_if.resp_data = 25'd1; a_if.resp_mask = 25'd0; step();
      a_if.resp_valid = 1'b0;
      check("mk_sig2", a_sig, 32'd3);
      step();
      check("mk_done", 32'(a_done), 32'd1);
      check("mk_pass", 32'(a_pass), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
